pattern_sequencer: RTL and testbench

Parametrised successor to the board's fixed 8-entry auto-drive path. It plays a loadable pattern table onto a WIDTH-bit stimulus bus at a programmable step rate, with one-shot, loop and ping-pong playback plus a manual pass-through mode. It sits between the board switch/key inputs and the `car` instances and replaces the separate clock divider, address counter and ROM chain with one single-clock block.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/tick_gen.sv | 33 +++
 rtl/pattern_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pattern_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the pattern sequencer: FSM state encoding and playback modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_e;

    // Playback modes as driven on the mode input
    localparam logic [1:0] MODE_MAN  = 2'd0;
    localparam logic [1:0] MODE_ONE  = 2'd1;
    localparam logic [1:0] MODE_LOOP = 2'd2;
    localparam logic [1:0] MODE_PING = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Step-rate divider: fires tick on the cycle its counter reaches TICK_DIV-1, then wraps.
// Latency: tick is combinational from the registered counter; clear takes effect next cycle.
// Backpressure: none; enable gates counting, clear has priority over enable.
// Ports: clock, reset_n (async active-low), enable, clear -> tick.
module tick_gen #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // With TICK_DIV=1 the counter is pinned at 0, so every enabled cycle ticks.
    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Plays a loadable pattern table onto a stimulus bus (one-shot/loop/ping-pong) or passes manual_in through.
// Latency: seq_out is registered, one cycle behind state/step; table writes reach seq_out 2 cycles after wr_en.
// Backpressure: none; start/stop are levels sampled every cycle, stop beats start.
// Ports: clock, reset_n, mode, start, stop, manual_in, wr_en/wr_addr/wr_data -> seq_out, step, busy, done.
module pattern_sequencer
    import seq_pkg::*;
#(
    parameter int   WIDTH    = 5,
    parameter int   DEPTH    = 8,
    parameter int   TICK_DIV = 20000000,
    // One bit wider than a bare table index when DEPTH is a power of two, so
    // out-of-range write addresses can actually be presented and rejected.
    localparam int  ADDR_W   = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  manual_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  seq_out,
    output logic [ADDR_W-1:0] step,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] step_q;
    logic              dir_up_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  seq_out_q;
    logic [WIDTH-1:0]  table_q [DEPTH];

    logic              run_en;
    logic              tick;
    logic [WIDTH-1:0]  rd_dat;
    logic [ADDR_W-1:0] ping_step_d;
    logic              ping_up_d;

    assign run_en = (state_q == S_RUN);

    // Counter is held at zero outside RUN, so every entry into RUN starts a full step interval.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (run_en),
        .clear   (!run_en),
        .tick    (tick)
    );

    // Pattern table: flop array, cleared by reset. Addresses without a
    // matching entry simply match nothing, which discards the write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    table_q[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (step_q == ADDR_W'(i)) begin
                rd_dat = table_q[i];
            end
        end
    end

    // Ping-pong successor: bounce at each end without re-emitting the endpoint.
    always_comb begin
        ping_step_d = step_q;
        ping_up_d   = dir_up_q;
        if (DEPTH > 1) begin
            if (dir_up_q) begin
                if (step_q >= LAST) begin
                    ping_step_d = step_q - 1'b1;
                    ping_up_d   = 1'b0;
                end else begin
                    ping_step_d = step_q + 1'b1;
                end
            end else begin
                if (step_q == '0) begin
                    ping_step_d = step_q + 1'b1;
                    ping_up_d   = 1'b1;
                end else begin
                    ping_step_d = step_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            dir_up_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            seq_out_q <= '0;
        end else begin
            done_q <= 1'b0;

            // Output follows the state/step of the current cycle, one cycle late.
            if (mode == MODE_MAN) begin
                seq_out_q <= manual_in;
            end else if (state_q == S_IDLE) begin
                seq_out_q <= '0;
            end else begin
                seq_out_q <= rd_dat;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !stop && (mode != MODE_MAN)) begin
                        state_q  <= S_RUN;
                        step_q   <= '0;
                        dir_up_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop || (mode == MODE_MAN)) begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        case (mode)
                            MODE_ONE: begin
                                if (step_q >= LAST) begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    step_q <= step_q + 1'b1;
                                end
                            end
                            MODE_LOOP: begin
                                step_q <= (step_q >= LAST) ? '0 : step_q + 1'b1;
                            end
                            default: begin
                                step_q   <= ping_step_d;
                                dir_up_q <= ping_up_d;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    step_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seq_out = seq_out_q;
    assign step    = step_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    localparam int WIDTH    = 5;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 3;
    localparam int ADDR_W   = 3;

    logic              clock;
    logic              reset_n;
    logic [1:0]        mode;
    logic              start;
    logic              stop;
    logic [WIDTH-1:0]  manual_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  seq_out;
    logic [ADDR_W-1:0] step;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    pattern_sequencer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .manual_in (manual_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .seq_out   (seq_out),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-shot seq_out after start edge N, samples after N+1..N+14
    logic [4:0] exp_os [14] = '{5'h01, 5'h01, 5'h01, 5'h02, 5'h02, 5'h02, 5'h04,
                                5'h04, 5'h04, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08};
    logic [2:0] exp_loop [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic [2:0] exp_ping [9]  = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

    initial begin
        reset_n   = 1'b0;
        mode      = 2'd1;
        start     = 1'b0;
        stop      = 1'b0;
        manual_in = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        #3;
        chk("rst_seq_out", 32'(seq_out), 32'h0);
        chk("rst_step",    32'(step),    32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_done",    32'(done),    32'h0);
        #9;
        reset_n = 1'b1;
        cyc();

        // Load table 01,02,04,08
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 5'(1 << i);
            cyc();
        end
        // Out-of-range write must be dropped
        wr_addr = 3'd4;
        wr_data = 5'h1F;
        cyc();
        wr_en = 1'b0;
        cyc();
        chk("idle_seq_out_zero", 32'(seq_out), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // One-shot
        mode  = 2'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("os_busy_at_start", 32'(busy), 32'h1);
        chk("os_step_at_start", 32'(step), 32'h0);
        for (int k = 1; k <= 14; k++) begin
            cyc();
            chk($sformatf("os_seq_out_k%0d", k), 32'(seq_out), 32'(exp_os[k-1]));
            chk($sformatf("os_done_k%0d", k), 32'(done), (k == 12) ? 32'h1 : 32'h0);
            chk($sformatf("os_busy_k%0d", k), 32'(busy), (k < 12) ? 32'h1 : 32'h0);
        end
        chk("os_step_held", 32'(step), 32'h3);

        // Loop, restarted from DONE
        mode  = 2'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int j = 0; j < 14; j++) begin
            if (j > 0) repeat (TICK_DIV) cyc();
            chk($sformatf("loop_step_j%0d", j), 32'(step), 32'(exp_loop[j]));
            chk($sformatf("loop_busy_j%0d", j), 32'(busy), 32'h1);
            chk($sformatf("loop_done_j%0d", j), 32'(done), 32'h0);
        end

        // Stop mid-run
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_step", 32'(step), 32'h0);
        cyc();
        chk("stop_seq_out", 32'(seq_out), 32'h0);

        // Start and stop together: stays idle
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", 32'(busy), 32'h0);
        cyc();
        chk("startstop_busy2", 32'(busy), 32'h0);
        chk("startstop_seq_out", 32'(seq_out), 32'h0);

        // Ping-pong
        mode  = 2'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if (j > 0) repeat (TICK_DIV) cyc();
            chk($sformatf("ping_step_j%0d", j), 32'(step), 32'(exp_ping[j]));
        end

        // Write to current step (2): visible 2 cycles after the wr_en cycle
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 5'h15;
        cyc();
        wr_en = 1'b0;
        chk("wr_cur_old", 32'(seq_out), 32'h04);
        cyc();
        chk("wr_cur_new", 32'(seq_out), 32'h15);
        chk("wr_cur_step", 32'(step), 32'h2);

        // Manual mode during RUN
        mode      = 2'd0;
        manual_in = 5'h1F;
        cyc();
        chk("man_run_seq_out", 32'(seq_out), 32'h1F);
        chk("man_run_busy", 32'(busy), 32'h0);
        chk("man_run_step", 32'(step), 32'h0);
        manual_in = 5'h0A;
        cyc();
        chk("man_idle_seq_out", 32'(seq_out), 32'h0A);

        // Reset mid-run
        mode  = 2'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("prerst_step", 32'(step), 32'h1);
        chk("prerst_seq_out", 32'(seq_out), 32'h02);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_seq_out", 32'(seq_out), 32'h0);
        chk("midrst_step",    32'(step),    32'h0);
        chk("midrst_busy",    32'(busy),    32'h0);
        chk("midrst_done",    32'(done),    32'h0);
        #2;
        reset_n = 1'b1;
        cyc();
        chk("postrst_seq_out", 32'(seq_out), 32'h0);

        // Table was cleared by reset: entry 0 now plays as 0
        mode  = 2'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("postrst_busy", 32'(busy), 32'h1);
        chk("postrst_table0", 32'(seq_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
